legv8_mc_ctrl: RTL and testbench

//  Multicycle control FSM for the 16-bit LEGv8 subset core. Sequences fetch, decode,

---
 rtl/legv8_pkg.sv | 49 ++++
 rtl/legv8_ctrl_decode.sv | 53 +++++
 rtl/legv8_mc_ctrl.sv | 153 +++++++++++++++
 tb/tb_legv8_mc_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
`default_nettype none
// =============================================================================
// Module  : legv8_pkg
// Brief   : Shared encodings for the 16-bit LEGv8 multicycle controller.
// Revision: 1.0
// =============================================================================
package legv8_pkg;

   localparam logic [2:0] OP_RTYPE = 3'd0;
   localparam logic [2:0] OP_LD    = 3'd3;
   localparam logic [2:0] OP_ST    = 3'd4;
   localparam logic [2:0] OP_CBZ   = 3'd5;
   localparam logic [2:0] OP_ADDI  = 3'd6;
   localparam logic [2:0] OP_ANDI  = 3'd7;

   localparam logic [2:0] FN_ADD = 3'd0;
   localparam logic [2:0] FN_SUB = 3'd1;
   localparam logic [2:0] FN_AND = 3'd2;
   localparam logic [2:0] FN_OR  = 3'd3;

   localparam logic [2:0] ALU_ADD    = 3'd0;
   localparam logic [2:0] ALU_SUB    = 3'd1;
   localparam logic [2:0] ALU_AND    = 3'd2;
   localparam logic [2:0] ALU_OR     = 3'd3;
   localparam logic [2:0] ALU_PASS_B = 3'd4;

   localparam logic PC_PLUS2  = 1'b0;
   localparam logic PC_BRANCH = 1'b1;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_e;

   typedef enum logic [2:0] {
      CL_RTYPE = 3'd0,
      CL_LD    = 3'd1,
      CL_ST    = 3'd2,
      CL_CBZ   = 3'd3,
      CL_ADDI  = 3'd4,
      CL_ANDI  = 3'd5,
      CL_RSVD  = 3'd6
   } iclass_e;

endpackage
`default_nettype wire

// File: rtl/legv8_ctrl_decode.sv
`default_nettype none
// =============================================================================
// Module  : legv8_ctrl_decode
// Brief   : Opcode/funct to instruction class, ALU operation and B-source.
// Revision: 1.0
// =============================================================================
module legv8_ctrl_decode
   import legv8_pkg::*;
(
   input  logic [2:0] opcode_i,
   input  logic [2:0] funct_i,
   output iclass_e    class_o,
   output logic [2:0] alu_op_o,
   output logic       alu_src_imm_o
);

   always_comb begin
      class_o       = CL_RSVD;
      alu_op_o      = ALU_ADD;
      alu_src_imm_o = 1'b0;
      case (opcode_i)
         OP_RTYPE: begin
            class_o  = CL_RTYPE;
            // funct codes 0..3 share the ALU encoding; 4..7 fall back to ADD
            alu_op_o = funct_i[2] ? ALU_ADD : funct_i;
         end
         OP_LD: begin
            class_o       = CL_LD;
            alu_src_imm_o = 1'b1;
         end
         OP_ST: begin
            class_o       = CL_ST;
            alu_src_imm_o = 1'b1;
         end
         OP_CBZ: begin
            class_o  = CL_CBZ;
            alu_op_o = ALU_PASS_B;
         end
         OP_ADDI: begin
            class_o       = CL_ADDI;
            alu_src_imm_o = 1'b1;
         end
         OP_ANDI: begin
            class_o       = CL_ANDI;
            alu_op_o      = ALU_AND;
            alu_src_imm_o = 1'b1;
         end
         default: class_o = CL_RSVD;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/legv8_mc_ctrl.sv
`default_nettype none
// =============================================================================
// Module  : legv8_mc_ctrl
// Brief   : Multicycle control FSM (fetch/decode/exec/mem/wb) with I/O wait.
// Revision: 1.0
// =============================================================================
module legv8_mc_ctrl
   import legv8_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             run,
   input  logic [2:0]       opcode,
   input  logic [2:0]       funct,
   input  logic             zero,
   input  logic             mem_rdy,
   output logic             ir_we,
   output logic             pc_we,
   output logic             pc_src,
   output logic             alu_src_imm,
   output logic [2:0]       alu_op,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic             reg_we,
   output logic             wb_sel,
   output logic             instr_done,
   output logic [1:0]       fault,
   output logic [CNT_W-1:0] retired
);

   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [1:0]        fault_q, fault_d;
   logic [CNT_W-1:0]  retired_q, retired_d;

   iclass_e    dec_class;
   logic [2:0] dec_alu_op;
   logic       dec_imm;
   logic       timeout;
   logic [1:0] fault_set;

   legv8_ctrl_decode u_decode (
      .opcode_i      (opcode),
      .funct_i       (funct),
      .class_o       (dec_class),
      .alu_op_o      (dec_alu_op),
      .alu_src_imm_o (dec_imm)
   );

   // Last permitted MEM cycle; the counter holds the number of cycles already spent there.
   assign timeout = (MEM_TIMEOUT != 0) && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

   always_comb begin
      state_d     = state_q;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      pc_src      = PC_PLUS2;
      alu_src_imm = 1'b0;
      alu_op      = ALU_ADD;
      mem_rd      = 1'b0;
      mem_wr      = 1'b0;
      reg_we      = 1'b0;
      wb_sel      = 1'b0;
      instr_done  = 1'b0;
      fault_set   = 2'b00;
      // Strobes are masked while reset is held so they drop the moment it asserts.
      if (reset) begin
         case (state_q)
            FETCH: begin
               if (run) begin
                  ir_we   = 1'b1;
                  pc_we   = 1'b1;
                  state_d = DECODE;
               end
            end
            DECODE: begin
               if (dec_class == CL_RSVD) begin
                  fault_set[0] = 1'b1;
                  instr_done   = 1'b1;
                  state_d      = FETCH;
               end else begin
                  state_d = EXEC;
               end
            end
            EXEC: begin
               alu_op      = dec_alu_op;
               alu_src_imm = dec_imm;
               if (dec_class == CL_CBZ) begin
                  pc_we      = zero;
                  pc_src     = zero ? PC_BRANCH : PC_PLUS2;
                  instr_done = 1'b1;
                  state_d    = FETCH;
               end else if ((dec_class == CL_LD) || (dec_class == CL_ST)) begin
                  state_d = MEM;
               end else begin
                  state_d = WB;
               end
            end
            MEM: begin
               mem_rd = (dec_class == CL_LD);
               mem_wr = (dec_class == CL_ST);
               if (mem_rdy) begin
                  if (dec_class == CL_LD) begin
                     state_d = WB;
                  end else begin
                     instr_done = 1'b1;
                     state_d    = FETCH;
                  end
               end else if (timeout) begin
                  fault_set[1] = 1'b1;
                  instr_done   = 1'b1;
                  state_d      = FETCH;
               end
            end
            WB: begin
               reg_we     = 1'b1;
               wb_sel     = (dec_class == CL_LD);
               instr_done = 1'b1;
               state_d    = FETCH;
            end
            default: state_d = FETCH;
         endcase
      end
   end

   assign wait_d    = ((state_q == MEM) && (state_d == MEM)) ? wait_q + WAIT_W'(1) : '0;
   assign fault_d   = fault_q | fault_set;
   assign retired_d = instr_done ? retired_q + CNT_W'(1) : retired_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= FETCH;
         wait_q    <= '0;
         fault_q   <= 2'b00;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         fault_q   <= fault_d;
         retired_q <= retired_d;
      end
   end

   assign fault   = fault_q;
   assign retired = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_legv8_mc_ctrl.sv
`default_nettype none
// =============================================================================
// Module  : tb_legv8_mc_ctrl
// Brief   : Directed self-checking bench for the multicycle control FSM.
// Revision: 1.0
// =============================================================================
module tb_legv8_mc_ctrl;

   logic clock, reset, run, zero, mem_rdy;
   logic [2:0] opcode, funct;

   logic ir_we, pc_we, pc_src, alu_src_imm, mem_rd, mem_wr, reg_we, wb_sel, instr_done;
   logic [2:0]  alu_op;
   logic [1:0]  fault;
   logic [15:0] retired;

   logic s_ir_we, s_pc_we, s_pc_src, s_imm, s_mem_rd, s_mem_wr, s_reg_we, s_wb_sel, s_done;
   logic [2:0] s_alu_op;
   logic [1:0] s_fault;
   logic [2:0] s_retired;

   logic [11:0] outv;
   assign outv = {ir_we, pc_we, pc_src, alu_src_imm, alu_op, mem_rd, mem_wr, reg_we, wb_sel, instr_done};

   int n_tests = 0;
   int n_fail  = 0;

   legv8_mc_ctrl #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
      .clock(clock), .reset(reset), .run(run), .opcode(opcode), .funct(funct),
      .zero(zero), .mem_rdy(mem_rdy), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
      .alu_src_imm(alu_src_imm), .alu_op(alu_op), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .reg_we(reg_we), .wb_sel(wb_sel), .instr_done(instr_done), .fault(fault),
      .retired(retired)
   );

   // Narrow counter instance sharing the stimulus, used to observe wrap-around.
   legv8_mc_ctrl #(.MEM_TIMEOUT(16), .CNT_W(3)) dut_small (
      .clock(clock), .reset(reset), .run(run), .opcode(opcode), .funct(funct),
      .zero(zero), .mem_rdy(mem_rdy), .ir_we(s_ir_we), .pc_we(s_pc_we), .pc_src(s_pc_src),
      .alu_src_imm(s_imm), .alu_op(s_alu_op), .mem_rd(s_mem_rd), .mem_wr(s_mem_wr),
      .reg_we(s_reg_we), .wb_sel(s_wb_sel), .instr_done(s_done), .fault(s_fault),
      .retired(s_retired)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Order: ir_we pc_we pc_src imm alu_op[2:0] mem_rd mem_wr reg_we wb_sel instr_done
   function automatic logic [11:0] v(input logic ir, input logic pw, input logic ps,
                                     input logic im, input logic [2:0] op, input logic rd,
                                     input logic wr, input logic rw, input logic wb,
                                     input logic dn);
      return {ir, pw, ps, im, op, rd, wr, rw, wb, dn};
   endfunction

   task automatic step(input string tag, input logic [11:0] exp);
      #2;
      chk(tag, 32'(outv), 32'(exp));
      @(posedge clock);
      #1;
   endtask

   task automatic alu_instr(input string tag, input logic [2:0] opc, input logic [2:0] fn,
                            input logic [2:0] exp_op, input logic exp_imm);
      opcode = opc;
      funct  = fn;
      step({tag, "_F"}, v(1, 1, 0, 0, 3'd0, 0, 0, 0, 0, 0));
      step({tag, "_D"}, v(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0));
      step({tag, "_E"}, v(0, 0, 0, exp_imm, exp_op, 0, 0, 0, 0, 0));
      step({tag, "_W"}, v(0, 0, 0, 0, 3'd0, 0, 0, 1, 0, 1));
   endtask

   initial begin
      reset = 1'b0; run = 1'b1; opcode = 3'd0; funct = 3'd0; zero = 1'b0; mem_rdy = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      step("rst_outputs", 12'h000);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_retired", 32'(retired), 32'd0);
      reset = 1'b1;

      // ADDI X4,XZR,#0x30
      alu_instr("addi", 3'd6, 3'd0, 3'd0, 1'b1);
      chk("addi_retired", 32'(retired), 32'd1);

      // LD from the switch port, ack on the 4th MEM cycle
      opcode = 3'd3;
      step("ld_F", v(1, 1, 0, 0, 3'd0, 0, 0, 0, 0, 0));
      step("ld_D", v(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0));
      step("ld_E", v(0, 0, 0, 1, 3'd0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 4; i++) begin
         mem_rdy = (i == 3);
         step("ld_M", v(0, 0, 0, 0, 3'd0, 1, 0, 0, 0, 0));
      end
      mem_rdy = 1'b0;
      step("ld_W", v(0, 0, 0, 0, 3'd0, 0, 0, 1, 1, 1));
      chk("ld_retired", 32'(retired), 32'd2);

      // CBZ taken, then not taken
      opcode = 3'd5; zero = 1'b1;
      step("cbz1_F", v(1, 1, 0, 0, 3'd0, 0, 0, 0, 0, 0));
      step("cbz1_D", v(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0));
      step("cbz1_E", v(0, 1, 1, 0, 3'd4, 0, 0, 0, 0, 1));
      zero = 1'b0;
      step("cbz0_F", v(1, 1, 0, 0, 3'd0, 0, 0, 0, 0, 0));
      step("cbz0_D", v(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0));
      step("cbz0_E", v(0, 0, 0, 0, 3'd4, 0, 0, 0, 0, 1));
      chk("cbz_retired", 32'(retired), 32'd4);

      alu_instr("sub", 3'd0, 3'd1, 3'd1, 1'b0);
      alu_instr("rfn6", 3'd0, 3'd6, 3'd0, 1'b0);
      alu_instr("andi", 3'd7, 3'd0, 3'd2, 1'b1);

      // ST to the 7-seg port, never acked: 16 MEM cycles then abort
      opcode = 3'd4;
      step("sto_F", v(1, 1, 0, 0, 3'd0, 0, 0, 0, 0, 0));
      step("sto_D", v(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0));
      step("sto_E", v(0, 0, 0, 1, 3'd0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 16; i++)
         step("sto_M", v(0, 0, 0, 0, 3'd0, 0, 1, 0, 0, (i == 15)));
      chk("sto_fault", 32'(fault), 32'd2);
      chk("sto_retired", 32'(retired), 32'd8);

      // ST acked on the 2nd MEM cycle
      step("st_F", v(1, 1, 0, 0, 3'd0, 0, 0, 0, 0, 0));
      step("st_D", v(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0));
      step("st_E", v(0, 0, 0, 1, 3'd0, 0, 0, 0, 0, 0));
      step("st_M1", v(0, 0, 0, 0, 3'd0, 0, 1, 0, 0, 0));
      mem_rdy = 1'b1;
      step("st_M2", v(0, 0, 0, 0, 3'd0, 0, 1, 0, 0, 1));
      mem_rdy = 1'b0;

      // Reserved opcode retires as a NOP in two cycles
      opcode = 3'd2;
      step("rsv_F", v(1, 1, 0, 0, 3'd0, 0, 0, 0, 0, 0));
      step("rsv_D", v(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 1));
      chk("rsv_fault", 32'(fault), 32'd3);
      chk("rsv_retired", 32'(retired), 32'd10);
      chk("wrap_retired", 32'(s_retired), 32'd2);

      run = 1'b0;
      step("idle1", 12'h000);
      step("idle2", 12'h000);
      chk("idle_retired", 32'(retired), 32'd10);
      run = 1'b1;

      // Reset asserted mid-MEM of an LD
      opcode = 3'd3;
      step("ldr_F", v(1, 1, 0, 0, 3'd0, 0, 0, 0, 0, 0));
      step("ldr_D", v(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0));
      step("ldr_E", v(0, 0, 0, 1, 3'd0, 0, 0, 0, 0, 0));
      step("ldr_M1", v(0, 0, 0, 0, 3'd0, 1, 0, 0, 0, 0));
      reset = 1'b0;
      #1;
      chk("ldr_async_out", 32'(outv), 32'd0);
      chk("ldr_async_fault", 32'(fault), 32'd0);
      chk("ldr_async_ret", 32'(retired), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      step("post_rst_F", v(1, 1, 0, 0, 3'd0, 0, 0, 0, 0, 0));
      step("post_rst_D", v(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
